// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// IDLE -> REQ -> WAIT -> RESP; only req_ready is combinational, everything else decodes registered state.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [63:0] ifu_resp_data,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [63:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_resp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic SIDE_IFU = 1'b0;
  localparam logic SIDE_LSU = 1'b1;

  state_t      state_q;
  logic        last_q;
  logic        owner_q;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] rdata_q;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        resp_taken;

  // On a tie the side not served last wins; rst gating keeps ready low during reset.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (ifu_req_valid && (!lsu_req_valid || last_q == SIDE_LSU)) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign resp_taken = (owner_q == SIDE_IFU) ? ifu_resp_ready : lsu_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_LSU;
      owner_q <= SIDE_IFU;
      wen_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
      rdata_q <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ifu) begin
            addr_q  <= ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= 64'd0;
            wmask_q <= 8'd0;
            owner_q <= SIDE_IFU;
            last_q  <= SIDE_IFU;
            state_q <= REQ;
          end else if (grant_lsu) begin
            addr_q  <= lsu_req_addr;
            wen_q   <= lsu_req_wen;
            wdata_q <= lsu_req_wdata;
            wmask_q <= lsu_req_wen ? lsu_req_wmask : 8'd0;
            owner_q <= SIDE_LSU;
            last_q  <= SIDE_LSU;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= wen_q ? 64'd0 : mem_resp_data;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_taken) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign ifu_resp_valid = (state_q == RESP) && (owner_q == SIDE_IFU);
  assign lsu_resp_valid = (state_q == RESP) && (owner_q == SIDE_LSU);
  assign ifu_resp_data  = rdata_q;
  assign lsu_resp_data  = rdata_q;
  assign busy           = (state_q != IDLE);
  assign owner          = owner_q;

endmodule
